// File: rtl/reg_file_wr_ctrl.sv
// Write-port controller for reg_file_wclk: zeroing sweep after reset/clear, then
// round-robin arbitration of two writeback requesters onto one registered write port.
module reg_file_wr_ctrl #(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned REG_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_a_valid,
  input  logic [REG_ADDR_SIZE-1:0] i_a_reg,
  input  logic [WORD_SIZE-1:0]     i_a_data,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic [REG_ADDR_SIZE-1:0] i_b_reg,
  input  logic [WORD_SIZE-1:0]     i_b_data,
  output logic                     o_b_ready,
  output logic                     o_busy,
  output logic                     o_reg_wr,
  output logic [REG_ADDR_SIZE-1:0] o_wr_reg,
  output logic [WORD_SIZE-1:0]     o_wr_data
);

  localparam logic [REG_ADDR_SIZE-1:0] LastIdx  = '1;
  localparam logic [REG_ADDR_SIZE-1:0] FirstIdx = REG_ADDR_SIZE'(1);

  typedef enum logic {StClear, StRun} state_e;

  state_e                   state_q, state_d;
  logic [REG_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic                     ptr_b_q, ptr_b_d;  // 1: B wins the next tie
  logic                     reg_wr_q, reg_wr_d;
  logic [REG_ADDR_SIZE-1:0] wr_reg_q, wr_reg_d;
  logic [WORD_SIZE-1:0]     wr_data_q, wr_data_d;
  logic                     grant_a, grant_b;

  // Grants are only ever raised for a valid requester, so grant == transfer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StRun && !i_clear) begin
      if (i_a_valid && i_b_valid) begin
        grant_a = !ptr_b_q;
        grant_b = ptr_b_q;
      end else begin
        grant_a = i_a_valid;
        grant_b = i_b_valid;
      end
    end
  end

  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;
  assign o_busy    = (state_q == StClear);
  assign o_reg_wr  = reg_wr_q;
  assign o_wr_reg  = wr_reg_q;
  assign o_wr_data = wr_data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_b_d   = ptr_b_q;
    reg_wr_d  = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StClear: begin
        reg_wr_d  = 1'b1;
        wr_reg_d  = cnt_q;
        wr_data_d = '0;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + FirstIdx;
        end
      end
      StRun: begin
        if (i_clear) begin
          state_d = StClear;
          cnt_d   = FirstIdx;
        end else if (grant_a) begin
          // Register 0 is hardwired zero: accept the request but suppress the strobe.
          reg_wr_d  = |i_a_reg;
          wr_reg_d  = i_a_reg;
          wr_data_d = i_a_data;
          ptr_b_d   = 1'b1;
        end else if (grant_b) begin
          reg_wr_d  = |i_b_reg;
          wr_reg_d  = i_b_reg;
          wr_data_d = i_b_data;
          ptr_b_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StClear;
      cnt_q     <= FirstIdx;
      ptr_b_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_b_q   <= ptr_b_d;
      reg_wr_q  <= reg_wr_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// Directed bench for reg_file_wr_ctrl with a per-cycle behavioural model and
// a shadow register file fed by the write port.
module tb_reg_file_wr_ctrl;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_reg, b_reg, wr_reg;
  logic [31:0] a_data, b_data, wr_data;
  logic        busy, reg_wr;

  int total = 0;
  int bad   = 0;

  reg_file_wr_ctrl #(.WORD_SIZE(32), .REG_ADDR_SIZE(5)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (clear),
    .i_a_valid(a_valid),
    .i_a_reg  (a_reg),
    .i_a_data (a_data),
    .o_a_ready(a_ready),
    .i_b_valid(b_valid),
    .i_b_reg  (b_reg),
    .i_b_data (b_data),
    .o_b_ready(b_ready),
    .o_busy   (busy),
    .o_reg_wr (reg_wr),
    .o_wr_reg (wr_reg),
    .o_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: sweeping flag, next sweep index, who was granted last.
  bit          m_init = 1'b0;
  bit          m_busy;
  int          m_idx;
  int          m_last;  // 1 = A granted last, 2 = B granted last
  logic        m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  function automatic int pick(input logic av, input logic bv, input int last);
    if (av && bv) return (last == 1) ? 2 : 1;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_busy <= 1'b1;
      m_idx  <= 1;
      m_last <= 2;
      m_wr   <= 1'b0;
      m_reg  <= '0;
      m_data <= '0;
    end else if (m_busy) begin
      m_wr   <= 1'b1;
      m_reg  <= 5'(m_idx);
      m_data <= '0;
      if (m_idx == NREG - 1) m_busy <= 1'b0;
      else m_idx <= m_idx + 1;
    end else if (clear) begin
      m_busy <= 1'b1;
      m_idx  <= 1;
      m_wr   <= 1'b0;
    end else begin
      case (pick(a_valid, b_valid, m_last))
        1: begin m_wr <= (a_reg != 0); m_reg <= a_reg; m_data <= a_data; m_last <= 1; end
        2: begin m_wr <= (b_reg != 0); m_reg <= b_reg; m_data <= b_data; m_last <= 2; end
        default: m_wr <= 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_busy",    32'(busy),    32'(m_busy));
      chk("cmp_reg_wr",  32'(reg_wr),  32'(m_wr));
      chk("cmp_wr_reg",  32'(wr_reg),  32'(m_reg));
      chk("cmp_wr_data", wr_data,      m_data);
      chk("cmp_a_ready", 32'(a_ready),
          32'(!m_busy && !clear && pick(a_valid, b_valid, m_last) == 1));
      chk("cmp_b_ready", 32'(b_ready),
          32'(!m_busy && !clear && pick(a_valid, b_valid, m_last) == 2));
      chk("cmp_one_hot", 32'(a_ready && b_ready), 32'(0));
    end
  end

  // Shadow of reg_file_wclk, written by the DUT's registered strobe.
  logic [31:0] rf [NREG];
  always @(posedge clk) if (reg_wr === 1'b1) rf[wr_reg] <= wr_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 1; i < NREG; i++) begin
      chk({tag, "_a_ready"}, 32'(a_ready), 32'(0));
      chk({tag, "_b_ready"}, 32'(b_ready), 32'(0));
      step();
      chk({tag, "_wr"},   32'(reg_wr), 32'(1));
      chk({tag, "_idx"},  32'(wr_reg), 32'(i));
      chk({tag, "_data"}, wr_data,     32'(0));
      chk({tag, "_busy"}, 32'(busy),   32'(i != NREG - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = 32'hx;
    rst = 1'b1; clear = 1'b0;
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
    b_valid = 1'b0; b_reg = '0;   b_data = '0;
    #1;

    // Reset held 3 cycles, then full sweep with A waiting.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy",    32'(busy),    32'(1));
      chk("rst_reg_wr",  32'(reg_wr),  32'(0));
      chk("rst_a_ready", 32'(a_ready), 32'(0));
    end
    rst = 1'b0;
    sweep("sweep0");

    // A accepted in the first RUN cycle.
    chk("a_first_ready", 32'(a_ready), 32'(1));
    step();
    a_valid = 1'b0;
    chk("a_wr",   32'(reg_wr), 32'(1));
    chk("a_reg",  32'(wr_reg), 32'(5));
    chk("a_data", wr_data,     32'hDEADBEEF);
    step();
    chk("idle_wr",   32'(reg_wr), 32'(0));
    chk("idle_hold", 32'(wr_reg), 32'(5));
    chk("rf5",       rf[5],       32'hDEADBEEF);
    chk("rf7_zero",  rf[7],       32'h0);

    // B to register 0: accepted, no strobe, pointer goes back to A.
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    chk("b0_ready",   32'(b_ready), 32'(1));
    chk("b0_a_ready", 32'(a_ready), 32'(0));
    step();
    b_valid = 1'b0;
    chk("b0_wr", 32'(reg_wr), 32'(0));

    // Continuous tie: A,B,A,B,A,B.
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h22;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_a_ready", 32'(a_ready), 32'(k % 2 == 0));
      chk("rr_b_ready", 32'(b_ready), 32'(k % 2 == 1));
      step();
      chk("rr_wr",   32'(reg_wr), 32'(1));
      chk("rr_reg",  32'(wr_reg), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", wr_data,     (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    b_valid = 1'b0;

    // Clear with A pending.
    a_reg = 5'd9; a_data = 32'h99; clear = 1'b1;
    #1;
    chk("clr_a_ready", 32'(a_ready), 32'(0));
    step();
    clear = 1'b0;
    chk("clr_busy", 32'(busy),   32'(1));
    chk("clr_wr",   32'(reg_wr), 32'(0));
    sweep("sweep1");
    chk("clr_a_first", 32'(a_ready), 32'(1));
    step();
    chk("clr_a_reg",  32'(wr_reg), 32'(9));
    chk("clr_a_data", wr_data,     32'h99);
    chk("rf1_zeroed", rf[1],       32'h0);

    // Reset at sweep index 12, restart from 1.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("mid_idx", 32'(wr_reg), 32'(12));
    rst = 1'b1;
    step();
    chk("mid_rst_wr",   32'(reg_wr), 32'(0));
    chk("mid_rst_busy", 32'(busy),   32'(1));
    rst = 1'b0;
    sweep("sweep2");
    chk("post_a_ready", 32'(a_ready), 32'(1));
    step();
    a_valid = 1'b0;
    chk("post_a_reg", 32'(wr_reg), 32'(9));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
